// File: rtl/timer_service_master.sv
// Avalon-MM master that programs the interval timer and services its IRQ in hardware.
// Counts ticks and optionally captures a 32-bit counter snapshot on every tick.
module timer_service_master #(
   parameter int unsigned TICK_W  = 16,
   parameter int unsigned SNAP_EN = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [31:0]       cfg_period,
   input  logic              start,
   input  logic              stop,
   output logic [2:0]        avm_address,
   output logic              avm_chipselect,
   output logic              avm_write_n,
   output logic              avm_read,
   output logic [15:0]       avm_writedata,
   input  logic [15:0]       avm_readdata,
   input  logic              avm_waitrequest,
   input  logic              timer_irq,
   output logic              busy,
   output logic              running,
   output logic              tick,
   output logic [TICK_W-1:0] tick_count,
   output logic [31:0]       snapshot,
   output logic              snapshot_valid
);

   localparam int unsigned ADDR_W   = 3;
   localparam int unsigned DATA_W   = 16;
   localparam int unsigned PERIOD_W = 32;

   localparam logic [ADDR_W-1:0] ADDR_STATUS = ADDR_W'(0);
   localparam logic [ADDR_W-1:0] ADDR_CTL    = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] ADDR_PL     = ADDR_W'(2);
   localparam logic [ADDR_W-1:0] ADDR_PH     = ADDR_W'(3);
   localparam logic [ADDR_W-1:0] ADDR_SNAP_L = ADDR_W'(4);
   localparam logic [ADDR_W-1:0] ADDR_SNAP_H = ADDR_W'(5);

   // Control word values: {stop, start, cont, ito}
   localparam logic [DATA_W-1:0] CTL_RUN  = DATA_W'(16'h0007);
   localparam logic [DATA_W-1:0] CTL_STOP = DATA_W'(16'h0008);

   typedef enum logic [3:0] {
      IDLE,
      WR_PL,
      WR_PH,
      WR_CTL,
      RUN,
      WR_ST,
      WR_SNAP,
      RD_SL,
      RD_SH,
      RD_CAP,
      GUARD,
      WR_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [PERIOD_W-1:0]   period_q, period_d;
   logic                  stop_pend_q, stop_pend_d;
   logic                  lo_pend_q, lo_pend_d;
   logic [DATA_W-1:0]     snap_lo_q, snap_lo_d;
   logic [2*DATA_W-1:0]   snapshot_q, snapshot_d;
   logic                  snap_valid_q, snap_valid_d;
   logic                  tick_q, tick_d;
   logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
   logic                  cs_q, cs_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic                  write_n_q, write_n_d;
   logic                  read_q, read_d;
   logic [DATA_W-1:0]     wdata_q, wdata_d;
   logic                  busy_q, busy_d;
   logic                  running_q, running_d;
   logic                  acc_c;

   assign acc_c = cs_q && !avm_waitrequest;

   // State and datapath registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         period_q     <= '0;
         stop_pend_q  <= 1'b0;
         lo_pend_q    <= 1'b0;
         snap_lo_q    <= '0;
         snapshot_q   <= '0;
         snap_valid_q <= 1'b0;
         tick_q       <= 1'b0;
         tick_cnt_q   <= '0;
         cs_q         <= 1'b0;
         addr_q       <= '0;
         write_n_q    <= 1'b1;
         read_q       <= 1'b0;
         wdata_q      <= '0;
         busy_q       <= 1'b0;
         running_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         period_q     <= period_d;
         stop_pend_q  <= stop_pend_d;
         lo_pend_q    <= lo_pend_d;
         snap_lo_q    <= snap_lo_d;
         snapshot_q   <= snapshot_d;
         snap_valid_q <= snap_valid_d;
         tick_q       <= tick_d;
         tick_cnt_q   <= tick_cnt_d;
         cs_q         <= cs_d;
         addr_q       <= addr_d;
         write_n_q    <= write_n_d;
         read_q       <= read_d;
         wdata_q      <= wdata_d;
         busy_q       <= busy_d;
         running_q    <= running_d;
      end
   end

   // Next-state and service datapath
   always_comb begin
      state_d      = state_q;
      period_d     = period_q;
      stop_pend_d  = stop_pend_q;
      lo_pend_d    = lo_pend_q;
      snap_lo_d    = snap_lo_q;
      snapshot_d   = snapshot_q;
      snap_valid_d = 1'b0;
      tick_d       = 1'b0;
      tick_cnt_d   = tick_cnt_q;

      // A stop mid-sequence is remembered and acted on once back in RUN
      if (stop && !(state_q inside {IDLE, RUN})) begin
         stop_pend_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               period_d = cfg_period;
               state_d  = WR_PL;
            end
         end
         WR_PL:  if (acc_c) state_d = WR_PH;
         WR_PH:  if (acc_c) state_d = WR_CTL;
         WR_CTL: if (acc_c) state_d = RUN;
         RUN: begin
            if (stop_pend_q || stop) begin
               state_d = WR_STOP;
            end else if (timer_irq) begin
               state_d = WR_ST;
            end
         end
         WR_ST: begin
            if (acc_c) begin
               tick_d     = 1'b1;
               tick_cnt_d = tick_cnt_q + TICK_W'(1);
               state_d    = (SNAP_EN != 0) ? WR_SNAP : GUARD;
            end
         end
         WR_SNAP: if (acc_c) state_d = RD_SL;
         RD_SL: begin
            if (acc_c) begin
               lo_pend_d = 1'b1;
               state_d   = RD_SH;
            end
         end
         RD_SH: begin
            // Low half is only valid in the first cycle after its read was accepted
            if (lo_pend_q) begin
               snap_lo_d = avm_readdata;
               lo_pend_d = 1'b0;
            end
            if (acc_c) state_d = RD_CAP;
         end
         RD_CAP: begin
            snapshot_d   = {avm_readdata, snap_lo_q};
            snap_valid_d = 1'b1;
            state_d      = GUARD;
         end
         GUARD: state_d = RUN;
         WR_STOP: begin
            if (acc_c) begin
               stop_pend_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Bus command and status flags decoded from the next state so they register with it
   always_comb begin
      cs_d      = 1'b0;
      addr_d    = '0;
      write_n_d = 1'b1;
      read_d    = 1'b0;
      wdata_d   = '0;

      case (state_d)
         WR_PL: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_PL;
            write_n_d = 1'b0;
            wdata_d   = period_d[DATA_W-1:0];
         end
         WR_PH: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_PH;
            write_n_d = 1'b0;
            wdata_d   = period_d[PERIOD_W-1:DATA_W];
         end
         WR_CTL: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_CTL;
            write_n_d = 1'b0;
            wdata_d   = CTL_RUN;
         end
         WR_ST: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_STATUS;
            write_n_d = 1'b0;
         end
         WR_SNAP: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_SNAP_L;
            write_n_d = 1'b0;
         end
         RD_SL: begin
            cs_d   = 1'b1;
            addr_d = ADDR_SNAP_L;
            read_d = 1'b1;
         end
         RD_SH: begin
            cs_d   = 1'b1;
            addr_d = ADDR_SNAP_H;
            read_d = 1'b1;
         end
         WR_STOP: begin
            cs_d      = 1'b1;
            addr_d    = ADDR_CTL;
            write_n_d = 1'b0;
            wdata_d   = CTL_STOP;
         end
         default: ;
      endcase

      busy_d    = !(state_d inside {IDLE, RUN});
      running_d = state_d inside {RUN, WR_ST, WR_SNAP, RD_SL, RD_SH, RD_CAP, GUARD};
   end

   assign avm_address    = addr_q;
   assign avm_chipselect = cs_q;
   assign avm_write_n    = write_n_q;
   assign avm_read       = read_q;
   assign avm_writedata  = wdata_q;
   assign busy           = busy_q;
   assign running        = running_q;
   assign tick           = tick_q;
   assign tick_count     = tick_cnt_q;
   assign snapshot       = snapshot_q;
   assign snapshot_valid = snap_valid_q;

endmodule

// File: tb/tb_timer_service_master.sv
// Directed bench for timer_service_master: cycle table for program/service, then
// hand sequences for stalls, stop arbitration, reset mid-sequence and tick wrap.
module tb_timer_service_master;

   localparam int unsigned TICK_W = 4;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [31:0]       cfg_period;
   logic              start;
   logic              stop;
   logic [2:0]        avm_address;
   logic              avm_chipselect;
   logic              avm_write_n;
   logic              avm_read;
   logic [15:0]       avm_writedata;
   logic [15:0]       avm_readdata;
   logic              avm_waitrequest;
   logic              timer_irq;
   logic              busy;
   logic              running;
   logic              tick;
   logic [TICK_W-1:0] tick_count;
   logic [31:0]       snapshot;
   logic              snapshot_valid;

   int checks   = 0;
   int failures = 0;

   timer_service_master #(.TICK_W(TICK_W), .SNAP_EN(1)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .cfg_period     (cfg_period),
      .start          (start),
      .stop           (stop),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write_n    (avm_write_n),
      .avm_read       (avm_read),
      .avm_writedata  (avm_writedata),
      .avm_readdata   (avm_readdata),
      .avm_waitrequest(avm_waitrequest),
      .timer_irq      (timer_irq),
      .busy           (busy),
      .running        (running),
      .tick           (tick),
      .tick_count     (tick_count),
      .snapshot       (snapshot),
      .snapshot_valid (snapshot_valid)
   );

   always #5 clk = ~clk;

   // Timer slave read port: data valid only in the cycle after an accepted read
   logic [15:0] sl_lo = 16'h1234;
   logic [15:0] sl_hi = 16'h0005;
   always @(posedge clk) begin
      if (avm_chipselect && avm_read && !avm_waitrequest)
         avm_readdata <= (avm_address == 3'd4) ? sl_lo :
                         (avm_address == 3'd5) ? sl_hi : 16'h0000;
      else
         avm_readdata <= 16'hDEAD;
   end

   // Log of accepted commands {read, address, writedata}
   logic [19:0] acc_log [0:255];
   int acc_cnt  = 0;
   int tick_seen = 0;
   int rd_ptr   = 0;
   always @(posedge clk) begin
      if (reset_n && avm_chipselect && !avm_waitrequest && acc_cnt < 256) begin
         acc_log[acc_cnt] <= {avm_read, avm_address, avm_writedata};
         acc_cnt <= acc_cnt + 1;
      end
      if (tick) tick_seen <= tick_seen + 1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_log(input string name, input logic rd, input logic [2:0] a,
                             input logic [15:0] d);
      checks++;
      if (rd_ptr >= acc_cnt) begin
         failures++;
         $display("FAIL %s: no accepted command, expected rd=%0b addr=%0d data=%h",
                  name, rd, a, d);
      end else begin
         if (acc_log[rd_ptr] !== {rd, a, d}) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, acc_log[rd_ptr], {rd, a, d});
         end
         rd_ptr++;
      end
   endtask

   function automatic logic [21:0] bus();
      return {avm_chipselect, avm_address, avm_write_n, avm_read, avm_writedata};
   endfunction

   function automatic logic [21:0] mkbus(input logic cs, input logic [2:0] a, input logic wn,
                                         input logic rd, input logic [15:0] wd);
      return {cs, a, wn, rd, wd};
   endfunction

   function automatic logic [61:0] outs();
      return {bus(), busy, running, tick, tick_count, snapshot_valid, snapshot};
   endfunction

   function automatic logic [61:0] mk(input logic cs, input logic [2:0] a, input logic wn,
                                      input logic rd, input logic [15:0] wd, input logic bz,
                                      input logic rn, input logic tk, input logic [3:0] tc,
                                      input logic sv, input logic [31:0] snap);
      return {cs, a, wn, rd, wd, bz, rn, tk, tc, sv, snap};
   endfunction

   typedef struct {
      logic        start;
      logic        stop;
      logic        irq;
      logic [31:0] period;
      logic [61:0] exp;
   } vec_t;

   vec_t vecs [11];

   localparam logic [21:0] IDLE_BUS = 22'({1'b0, 3'd0, 1'b1, 1'b0, 16'h0000});

   initial begin
      int t0;
      // Program with 0x186A0, then one full tick service with snapshot 0x0005_1234
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'h000186A0, mk(1,3'd2,0,0,16'h86A0, 1,0,0,4'd0,0,32'h0)};
      vecs[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(1,3'd3,0,0,16'h0001, 1,0,0,4'd0,0,32'h0)};
      vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(1,3'd1,0,0,16'h0007, 1,0,0,4'd0,0,32'h0)};
      vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(0,3'd0,1,0,16'h0000, 0,1,0,4'd0,0,32'h0)};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'h0,        mk(1,3'd0,0,0,16'h0000, 1,1,0,4'd0,0,32'h0)};
      vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'h0,        mk(1,3'd4,0,0,16'h0000, 1,1,1,4'd1,0,32'h0)};
      vecs[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(1,3'd4,1,1,16'h0000, 1,1,0,4'd1,0,32'h0)};
      vecs[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(1,3'd5,1,1,16'h0000, 1,1,0,4'd1,0,32'h0)};
      vecs[8]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(0,3'd0,1,0,16'h0000, 1,1,0,4'd1,0,32'h0)};
      vecs[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(0,3'd0,1,0,16'h0000, 1,1,0,4'd1,1,32'h00051234)};
      vecs[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        mk(0,3'd0,1,0,16'h0000, 0,1,0,4'd1,0,32'h00051234)};

      reset_n = 1'b0; cfg_period = '0; start = 0; stop = 0; timer_irq = 0; avm_waitrequest = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_outs", 64'(outs()), 64'(mk(0,3'd0,1,0,16'h0,0,0,0,4'd0,0,32'h0)));
      @(negedge clk) reset_n = 1'b1;
      step();
      chk("idle_after_reset", 64'(outs()), 64'(mk(0,3'd0,1,0,16'h0,0,0,0,4'd0,0,32'h0)));

      for (int i = 0; i < 11; i++) begin
         start = vecs[i].start; stop = vecs[i].stop; timer_irq = vecs[i].irq;
         cfg_period = vecs[i].period;
         step();
         chk($sformatf("vec%0d", i), 64'(outs()), 64'(vecs[i].exp));
      end
      expect_log("log_pl",   0, 3'd2, 16'h86A0);
      expect_log("log_ph",   0, 3'd3, 16'h0001);
      expect_log("log_ctl",  0, 3'd1, 16'h0007);
      expect_log("log_st",   0, 3'd0, 16'h0000);
      expect_log("log_snap", 0, 3'd4, 16'h0000);
      expect_log("log_rsl",  1, 3'd4, 16'h0000);
      expect_log("log_rsh",  1, 3'd5, 16'h0000);

      // Stop and irq together in RUN: stop wins, no tick
      stop = 1; timer_irq = 1;
      step();
      chk("stopirq_bus", 64'(bus()), 64'(mkbus(1,3'd1,0,0,16'h0008)));
      chk("stopirq_tick", 64'(tick), 64'(0));
      stop = 0; timer_irq = 0;
      step();
      chk("stopirq_idle", 64'({bus(), busy, running, tick_count}),
          64'({IDLE_BUS, 1'b0, 1'b0, 4'd1}));
      expect_log("log_stop1", 0, 3'd1, 16'h0008);

      // Stall WR_PH for 3 cycles
      sl_lo = 16'hAAAA; sl_hi = 16'h0BBB;
      start = 1; cfg_period = 32'hCAFEBEEF;
      step();
      chk("stall_pl", 64'(bus()), 64'(mkbus(1,3'd2,0,0,16'hBEEF)));
      start = 0;
      step();
      chk("stall_ph", 64'(bus()), 64'(mkbus(1,3'd3,0,0,16'hCAFE)));
      avm_waitrequest = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold_ph%0d", i), 64'(bus()), 64'(mkbus(1,3'd3,0,0,16'hCAFE)));
      end
      avm_waitrequest = 0;
      step();
      chk("stall_ctl", 64'(bus()), 64'(mkbus(1,3'd1,0,0,16'h0007)));
      step();
      chk("stall_run", 64'({busy, running}), 64'(2'b01));
      expect_log("log_s_pl",  0, 3'd2, 16'hBEEF);
      expect_log("log_s_ph",  0, 3'd3, 16'hCAFE);
      expect_log("log_s_ctl", 0, 3'd1, 16'h0007);

      // Stall RD_SH for 3 cycles; low half must survive the stall
      timer_irq = 1;
      step();
      step();
      chk("stall_tick", 64'({tick, tick_count}), 64'({1'b1, 4'd2}));
      timer_irq = 0;
      step();
      step();
      chk("stall_rsh", 64'(bus()), 64'(mkbus(1,3'd5,1,1,16'h0)));
      avm_waitrequest = 1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("hold_rsh%0d", i), 64'(bus()), 64'(mkbus(1,3'd5,1,1,16'h0)));
      end
      avm_waitrequest = 0;
      step();
      step();
      chk("stall_snap", 64'({snapshot_valid, snapshot}), 64'({1'b1, 32'h0BBBAAAA}));
      step();
      chk("stall_snap_pulse", 64'({snapshot_valid, running, busy}), 64'(3'b010));
      expect_log("log_s_st",  0, 3'd0, 16'h0);
      expect_log("log_s_sn",  0, 3'd4, 16'h0);
      expect_log("log_s_rsl", 1, 3'd4, 16'h0);
      expect_log("log_s_rsh", 1, 3'd5, 16'h0);

      // Stop during WR_SNAP: service completes, then stop write
      sl_lo = 16'h1234; sl_hi = 16'h0005;
      timer_irq = 1;
      step();
      step();
      chk("sp_in_snap", 64'(bus()), 64'(mkbus(1,3'd4,0,0,16'h0)));
      timer_irq = 0; stop = 1;
      step();
      stop = 0;
      chk("sp_rsl", 64'(bus()), 64'(mkbus(1,3'd4,1,1,16'h0)));
      step();
      step();
      step();
      chk("sp_snap", 64'({snapshot_valid, snapshot, tick_count}), 64'({1'b1, 32'h00051234, 4'd3}));
      step();
      chk("sp_run", 64'({busy, running}), 64'(2'b01));
      step();
      chk("sp_wrstop", 64'(bus()), 64'(mkbus(1,3'd1,0,0,16'h0008)));
      step();
      chk("sp_idle", 64'({bus(), busy, running}), 64'({IDLE_BUS, 2'b00}));
      expect_log("log_p_st",  0, 3'd0, 16'h0);
      expect_log("log_p_sn",  0, 3'd4, 16'h0);
      expect_log("log_p_rsl", 1, 3'd4, 16'h0);
      expect_log("log_p_rsh", 1, 3'd5, 16'h0);
      expect_log("log_p_stp", 0, 3'd1, 16'h0008);

      // Asynchronous reset while in RD_SL
      start = 1; cfg_period = 32'h00000010;
      step();
      start = 0;
      repeat (3) step();
      timer_irq = 1;
      step();
      step();
      timer_irq = 0;
      step();
      chk("rst_pre_rsl", 64'(bus()), 64'(mkbus(1,3'd4,1,1,16'h0)));
      reset_n = 1'b0;
      #1;
      chk("rst_bus", 64'(bus()), 64'(IDLE_BUS));
      chk("rst_flags", 64'({busy, running, tick, tick_count, snapshot_valid, snapshot}), 64'(0));
      @(negedge clk) reset_n = 1'b1;
      step();
      chk("rst_idle", 64'(outs()), 64'(mk(0,3'd0,1,0,16'h0,0,0,0,4'd0,0,32'h0)));
      rd_ptr = acc_cnt;

      // Fresh start reprograms the timer
      start = 1; cfg_period = 32'h000186A0;
      step();
      start = 0;
      repeat (3) step();
      chk("re_run", 64'({busy, running}), 64'(2'b01));
      expect_log("log_r_pl",  0, 3'd2, 16'h86A0);
      expect_log("log_r_ph",  0, 3'd3, 16'h0001);
      expect_log("log_r_ctl", 0, 3'd1, 16'h0007);

      // 17 services with a 4-bit counter wrap to 1
      t0 = tick_seen;
      for (int i = 0; i < 17; i++) begin
         timer_irq = 1;
         step();
         step();
         timer_irq = 0;
         repeat (5) step();
      end
      step();
      chk("wrap_count", 64'(tick_count), 64'(4'd1));
      chk("wrap_pulses", 64'(tick_seen - t0), 64'(17));
      chk("wrap_run", 64'({busy, running}), 64'(2'b01));

      // start while running is ignored
      rd_ptr = acc_cnt;
      start = 1; cfg_period = 32'h12345678;
      step();
      start = 0;
      repeat (4) step();
      chk("ign_start_bus", 64'(acc_cnt - rd_ptr), 64'(0));
      chk("ign_start_state", 64'({bus(), running, tick_count}), 64'({IDLE_BUS, 1'b1, 4'd1}));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
